// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage of the 9-bit accumulator core.
// The jump-target table lives here so the assembler and RTL read one copy.
package fetch_unit_pkg;

    localparam int PC_W_DEF       = 10;
    localparam int START_ADDR_DEF = 0;
    localparam int CNT_W_DEF      = 16;
    localparam int LUT_W          = 10;

    typedef enum logic [3:0] {
        OP_LDA  = 4'h0,
        OP_STA  = 4'h1,
        OP_ADD  = 4'h2,
        OP_SUB  = 4'h3,
        OP_AND  = 4'h4,
        OP_OR   = 4'h5,
        OP_XOR  = 4'h6,
        OP_SHL  = 4'h7,
        OP_SHR  = 4'h8,
        OP_LDI  = 4'h9,
        OP_BEQ  = 4'hA,
        OP_BGE  = 4'hB,
        OP_BNE  = 4'hC,
        OP_JMP  = 4'hD,
        OP_NOP  = 4'hE,
        OP_DONE = 4'hF
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam logic [LUT_W-1:0] JMP_LUT [16] = '{
        10'h000, 10'h010, 10'h020, 10'h040,
        10'h080, 10'h0AB, 10'h100, 10'h155,
        10'h200, 10'h25A, 10'h300, 10'h3F0,
        10'h3FF, 10'h025, 10'h123, 10'h3FE
    };

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle between the fetch stage and its surroundings (decoder, ALU, bench).
interface fetch_unit_if #(
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
);
    import fetch_unit_pkg::*;

    // start/ack handshake: a 1-then-0 on start launches a run from IDLE;
    // ack rises the cycle after DONE and stays high until start=1 is seen.
    logic              start;
    logic              jump_en;
    logic              jmp_cond;
    logic [3:0]        jmp_idx;
    logic              branch_en;
    logic              branch_taken;
    logic              done_in;
    logic [PC_W-1:0]   prog_ctr;
    logic              ack;
    logic              running;
    logic [CNT_W-1:0]  cycle_cnt;
    fetch_state_t      state;

    modport master (
        output start, jump_en, jmp_cond, jmp_idx, branch_en, branch_taken, done_in,
        input  prog_ctr, ack, running, cycle_cnt, state
    );

    modport slave (
        input  start, jump_en, jmp_cond, jmp_idx, branch_en, branch_taken, done_in,
        output prog_ctr, ack, running, cycle_cnt, state
    );

endinterface

// File: rtl/fetch_unit_jump_lut.sv
// Combinational jump-target lookup from the shared package table.
module fetch_unit_jump_lut
    import fetch_unit_pkg::*;
#(
    parameter int PC_W = PC_W_DEF
) (
    input  logic [3:0]      idx,
    output logic [PC_W-1:0] target
);

    logic [LUT_W-1:0] word;

    assign word   = JMP_LUT[idx];
    assign target = PC_W'(word);

endmodule

// File: rtl/fetch_unit.sv
// Program counter and run/halt sequencing for the accumulator core,
// with a saturating run-cycle counter for performance reporting.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int PC_W       = PC_W_DEF,
    parameter int START_ADDR = START_ADDR_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.slave  bus
);

    localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

    fetch_state_t     state;
    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  jmp_target;
    logic [CNT_W-1:0] cnt;
    logic             ack;
    logic             cond_flag;
    logic             start_q;
    logic             start_fall;
    logic             jump_taken;

    fetch_unit_jump_lut #(.PC_W(PC_W)) u_lut (
        .idx    (bus.jmp_idx),
        .target (jmp_target)
    );

    assign start_fall = start_q & ~bus.start;
    // Jump uses the flag as it stood before any same-cycle branch update.
    assign jump_taken = bus.jump_en & (~bus.jmp_cond | cond_flag);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= START_PC;
            cnt       <= '0;
            ack       <= 1'b0;
            cond_flag <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            start_q <= bus.start;
            case (state)
                IDLE: begin
                    pc        <= START_PC;
                    cnt       <= '0;
                    cond_flag <= 1'b0;
                    ack       <= 1'b0;
                    if (start_fall) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                    if (bus.branch_en) begin
                        cond_flag <= bus.branch_taken;
                    end
                    if (bus.done_in) begin
                        state <= HALT;
                        ack   <= 1'b1;
                    end else if (jump_taken) begin
                        pc <= jmp_target;
                    end else begin
                        pc <= pc + 1'b1;
                    end
                end
                HALT: begin
                    if (bus.start) begin
                        state <= IDLE;
                        ack   <= 1'b0;
                        pc    <= START_PC;
                    end
                end
                default: begin
                    state <= IDLE;
                    pc    <= START_PC;
                    ack   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.prog_ctr  = pc;
    assign bus.ack       = ack;
    assign bus.running   = (state == RUN);
    assign bus.cycle_cnt = cnt;
    assign bus.state     = state;

endmodule
